// File: rtl/intersection_ctrl_pkg.sv
// Shared trafficlight codes, FSM state encodings and the state-to-lights decode.
// Latency: none (constants and a pure function).
// Backpressure: n/a.
// Light codes are the same values the car driver module consumes: green 00, yellow 01, red 10.
package intersection_ctrl_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  localparam logic [2:0] ST_MAIN_G    = 3'd0;
  localparam logic [2:0] ST_MAIN_Y    = 3'd1;
  localparam logic [2:0] ST_ALL_RED_A = 3'd2;
  localparam logic [2:0] ST_SIDE_G    = 3'd3;
  localparam logic [2:0] ST_SIDE_Y    = 3'd4;
  localparam logic [2:0] ST_ALL_RED_B = 3'd5;

  typedef struct packed {
    logic [1:0] main_l;
    logic [1:0] side_l;
  } lights_t;

  // Every state keeps at least one road red; unused codes decode to all-red.
  function automatic lights_t lights_of(input logic [2:0] st);
    lights_t l;
    l.main_l = LIGHT_RED;
    l.side_l = LIGHT_RED;
    case (st)
      ST_MAIN_G: l.main_l = LIGHT_GREEN;
      ST_MAIN_Y: l.main_l = LIGHT_YELLOW;
      ST_SIDE_G: l.side_l = LIGHT_GREEN;
      ST_SIDE_Y: l.side_l = LIGHT_YELLOW;
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase timer: cycles spent in the current FSM state, cleared on state entry, saturating.
// Latency: cnt reads 0 on the first cycle after a clr edge.
// Backpressure: none.
// Ports: clk, rst_n (sync, active-low), clr (a state change happens on this edge), cnt.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way intersection sequencer with all-red clearance and latched pedestrian requests.
// Latency: all outputs registered, decoded from next state (valid the cycle a state begins).
// Backpressure: none; side_car is a level, ped_req is latched until served.
// Ports: clk, rst_n (sync, active-low), side_car, ped_req in;
//        main_light[1:0], side_light[1:0], walk, ped_ack out.
module intersection_ctrl #(
  parameter int MAIN_MIN = 20,
  parameter int SIDE_MIN = 8,
  parameter int SIDE_MAX = 30,
  parameter int YELLOW   = 5,
  parameter int ALL_RED  = 2,
  parameter int WALK     = 6,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk,
  output logic       ped_ack
);

  import intersection_ctrl_pkg::*;

  // Last cnt value of each timed phase (a phase of length N exits at cnt == N-1).
  localparam logic [CNT_W-1:0] MAIN_LAST  = CNT_W'(MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] SMIN_LAST  = CNT_W'(SIDE_MIN - 1);
  localparam logic [CNT_W-1:0] SMAX_LAST  = CNT_W'(SIDE_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ped_pend;
  logic             walk_en;     // current side phase was entered with a pending ped request
  logic             enter_side;
  lights_t          lights_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_MAIN_G:    if (cnt >= MAIN_LAST && (side_car || ped_pend)) state_nxt = ST_MAIN_Y;
      ST_MAIN_Y:    if (cnt == YEL_LAST) state_nxt = ST_ALL_RED_A;
      ST_ALL_RED_A: if (cnt == RED_LAST) state_nxt = ST_SIDE_G;
      ST_SIDE_G:    if ((cnt >= SMIN_LAST && !side_car) || cnt == SMAX_LAST) state_nxt = ST_SIDE_Y;
      ST_SIDE_Y:    if (cnt == YEL_LAST) state_nxt = ST_ALL_RED_B;
      ST_ALL_RED_B: if (cnt == RED_LAST) state_nxt = ST_MAIN_G;
      default:      state_nxt = ST_ALL_RED_B;
    endcase
  end

  assign enter_side = (state_nxt == ST_SIDE_G) && (state != ST_SIDE_G);
  assign lights_nxt = lights_of(state_nxt);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_nxt != state),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_ALL_RED_B;
      ped_pend   <= 1'b0;
      walk_en    <= 1'b0;
      main_light <= LIGHT_RED;
      side_light <= LIGHT_RED;
      walk       <= 1'b0;
      ped_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      main_light <= lights_nxt.main_l;
      side_light <= lights_nxt.side_l;
      ped_ack    <= enter_side && ped_pend;
      if (enter_side) begin
        // Entering side green serves the pending request; a ped_req on this
        // same edge is absorbed by the phase being entered.
        ped_pend <= 1'b0;
        walk_en  <= ped_pend;
        walk     <= ped_pend;
      end else begin
        if (ped_req) ped_pend <= 1'b1;
        // cnt is the value before this edge, so the cycle being entered has cnt+1.
        walk <= (state_nxt == ST_SIDE_G) && walk_en && (cnt < WALK_LAST);
      end
    end
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
module tb_intersection_ctrl;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       side_car;
  logic       ped_req;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       walk;
  logic       ped_ack;

  always #5 clk = ~clk;

  intersection_ctrl #(
    .MAIN_MIN(8), .SIDE_MIN(4), .SIDE_MAX(12), .YELLOW(3), .ALL_RED(2), .WALK(4), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .side_car   (side_car),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .ped_ack    (ped_ack)
  );

  // Inputs applied before an edge, outputs expected right after that edge.
  typedef struct {
    logic       rn;
    logic       car;
    logic       ped;
    logic [1:0] m;
    logic [1:0] s;
    logic       w;
    logic       a;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int n, input logic rn, input logic car, input logic ped,
                     input logic [1:0] m, input logic [1:0] s, input logic w, input logic a);
    vec_t v;
    v.rn = rn; v.car = car; v.ped = ped; v.m = m; v.s = s; v.w = w; v.a = a;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acks;
    int walks;
    int sgreens;

    rst_n = 1'b0; side_car = 1'b0; ped_req = 1'b0;

    // Reset for two cycles, then release: one more red cycle, then main green.
    add(2, 0, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, R, R, 0, 0);
    // side_car held from main-green entry: full cycle with side at SIDE_MAX.
    add(8, 1, 1, 0, G, R, 0, 0);
    add(3, 1, 1, 0, Y, R, 0, 0);
    add(2, 1, 1, 0, R, R, 0, 0);
    add(12, 1, 1, 0, R, G, 0, 0);
    add(3, 1, 1, 0, R, Y, 0, 0);
    add(2, 1, 1, 0, R, R, 0, 0);
    // ped_req pulse sampled at MAIN_G cnt=2; side green exactly SIDE_MIN with walk.
    add(3, 1, 0, 0, G, R, 0, 0);
    add(1, 1, 0, 1, G, R, 0, 0);
    add(4, 1, 0, 0, G, R, 0, 0);
    add(3, 1, 0, 0, Y, R, 0, 0);
    add(2, 1, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, R, G, 1, 1);
    add(3, 1, 0, 0, R, G, 1, 0);
    add(3, 1, 0, 0, R, Y, 0, 0);
    add(2, 1, 0, 0, R, R, 0, 0);
    // No requests: main stays green.
    add(100, 1, 0, 0, G, R, 0, 0);
    // Ped served, re-requested at SIDE_G cnt0, then reset at SIDE_G cnt1 drops it.
    add(1, 1, 0, 1, G, R, 0, 0);
    add(3, 1, 0, 0, Y, R, 0, 0);
    add(2, 1, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, R, G, 1, 1);
    add(1, 1, 0, 1, R, G, 1, 0);
    add(1, 0, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, R, R, 0, 0);
    add(20, 1, 0, 0, G, R, 0, 0);
    // Car-triggered side phase; ped_req during it acks only on the next side entry.
    add(1, 1, 1, 0, Y, R, 0, 0);
    add(2, 1, 0, 0, Y, R, 0, 0);
    add(2, 1, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, R, G, 0, 0);
    add(1, 1, 0, 1, R, G, 0, 0);
    add(2, 1, 0, 0, R, G, 0, 0);
    add(3, 1, 0, 0, R, Y, 0, 0);
    add(2, 1, 0, 0, R, R, 0, 0);
    add(8, 1, 0, 0, G, R, 0, 0);
    add(3, 1, 0, 0, Y, R, 0, 0);
    add(2, 1, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, R, G, 1, 1);
    add(3, 1, 0, 0, R, G, 1, 0);
    add(3, 1, 0, 0, R, Y, 0, 0);
    add(2, 1, 0, 0, R, R, 0, 0);
    add(1, 1, 0, 0, G, R, 0, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rn; side_car = vecs[i].car; ped_req = vecs[i].ped;
      step();
      chk($sformatf("row%0d main", i), main_light, vecs[i].m);
      chk($sformatf("row%0d side", i), side_light, vecs[i].s);
      chk($sformatf("row%0d walk", i), {1'b0, walk}, {1'b0, vecs[i].w});
      chk($sformatf("row%0d ack", i), {1'b0, ped_ack}, {1'b0, vecs[i].a});
      chk($sformatf("row%0d safety", i), {1'b0, (main_light == R) || (side_light == R)}, 2'b01);
    end
    rst_n = 1'b1; side_car = 1'b0; ped_req = 1'b0;

    // ped_req held for three cycles in MAIN_G: exactly one ack, four walk cycles.
    acks = 0; walks = 0; sgreens = 0;
    ped_req = 1'b1;
    repeat (3) step();
    ped_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (ped_ack) acks++;
      if (walk) walks++;
      if (side_light == G) sgreens++;
      if (main_light != R && side_light != R) begin
        errors++;
        $display("FAIL held_ped safety: main %b side %b", main_light, side_light);
      end
    end
    chk_int("held_ped acks", acks, 1);
    chk_int("held_ped walk cycles", walks, 4);
    chk_int("held_ped side green cycles", sgreens, 4);

    // Counter saturation: after 258 idle green cycles cnt must read 255 (not 2),
    // so a car request leaves main green on the very next edge.
    rst_n = 1'b0;
    step();
    chk("sat reset main", main_light, R);
    rst_n = 1'b1;
    step();
    chk("sat release main", main_light, R);
    step();
    chk("sat green entry", main_light, G);
    repeat (258) step();
    chk("sat still green", main_light, G);
    side_car = 1'b1;
    step();
    chk("sat immediate yellow", main_light, Y);
    chk("sat side red", side_light, R);
    side_car = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
